// File: rtl/cpu_ops_pkg.sv
// Shared CPU operation constants: opcodes, ALU select codes, op classes and
// the ALU sequencer state encoding. Used by the ALU, decoder and sequencer.
package cpu_ops_pkg;

  localparam int OP_W  = 5;
  localparam int SEL_W = 5;
  localparam int RA_W  = 4;

  // ISA opcodes
  localparam logic [OP_W-1:0] OPC_LD   = 5'd0;
  localparam logic [OP_W-1:0] OPC_LDI  = 5'd1;
  localparam logic [OP_W-1:0] OPC_ST   = 5'd2;
  localparam logic [OP_W-1:0] OPC_ADD  = 5'd3;
  localparam logic [OP_W-1:0] OPC_SUB  = 5'd4;
  localparam logic [OP_W-1:0] OPC_AND  = 5'd5;
  localparam logic [OP_W-1:0] OPC_OR   = 5'd6;
  localparam logic [OP_W-1:0] OPC_ROR  = 5'd7;
  localparam logic [OP_W-1:0] OPC_ROL  = 5'd8;
  localparam logic [OP_W-1:0] OPC_SHR  = 5'd9;
  localparam logic [OP_W-1:0] OPC_SHRA = 5'd10;
  localparam logic [OP_W-1:0] OPC_SHL  = 5'd11;
  localparam logic [OP_W-1:0] OPC_ADDI = 5'd12;
  localparam logic [OP_W-1:0] OPC_ANDI = 5'd13;
  localparam logic [OP_W-1:0] OPC_ORI  = 5'd14;
  localparam logic [OP_W-1:0] OPC_DIV  = 5'd15;
  localparam logic [OP_W-1:0] OPC_MUL  = 5'd16;
  localparam logic [OP_W-1:0] OPC_NEG  = 5'd17;
  localparam logic [OP_W-1:0] OPC_NOT  = 5'd18;

  // ALU select codes; 0 means no operation
  localparam logic [SEL_W-1:0] ALU_NOP   = 5'd0;
  localparam logic [SEL_W-1:0] ALU_ADD   = 5'd1;
  localparam logic [SEL_W-1:0] ALU_SUB   = 5'd2;
  localparam logic [SEL_W-1:0] ALU_AND   = 5'd3;
  localparam logic [SEL_W-1:0] ALU_OR    = 5'd4;
  localparam logic [SEL_W-1:0] ALU_NEG   = 5'd5;
  localparam logic [SEL_W-1:0] ALU_NOT   = 5'd6;
  localparam logic [SEL_W-1:0] ALU_SHR   = 5'd7;
  localparam logic [SEL_W-1:0] ALU_SHL   = 5'd8;
  localparam logic [SEL_W-1:0] ALU_ROR   = 5'd9;
  localparam logic [SEL_W-1:0] ALU_ROL   = 5'd10;
  localparam logic [SEL_W-1:0] ALU_DIV   = 5'd11;
  localparam logic [SEL_W-1:0] ALU_MUL   = 5'd12;
  localparam logic [SEL_W-1:0] ALU_SHRA  = 5'd13;
  localparam logic [SEL_W-1:0] ALU_INCPC = 5'd14;

  // Operation classes: reg-reg, reg-immediate, unary, mul/div, illegal
  typedef enum logic [2:0] {
    CLS_RR  = 3'd0,
    CLS_RI  = 3'd1,
    CLS_UN  = 3'd2,
    CLS_MD  = 3'd3,
    CLS_ILL = 3'd4
  } op_class_e;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T3   = 3'd1;
  localparam logic [2:0] ST_T4   = 3'd2;
  localparam logic [2:0] ST_T5   = 3'd3;
  localparam logic [2:0] ST_T6   = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decoder: opcode -> operation class and ALU select code.
module alu_op_decode
  import cpu_ops_pkg::*;
(
  input  logic [OP_W-1:0]  opcode,
  output op_class_e        op_class,
  output logic [SEL_W-1:0] alu_select
);

  // Map each supported opcode to its class and ALU function
  always_comb begin
    op_class   = CLS_ILL;
    alu_select = ALU_NOP;
    case (opcode)
      OPC_ADD:  begin op_class = CLS_RR; alu_select = ALU_ADD;  end
      OPC_SUB:  begin op_class = CLS_RR; alu_select = ALU_SUB;  end
      OPC_AND:  begin op_class = CLS_RR; alu_select = ALU_AND;  end
      OPC_OR:   begin op_class = CLS_RR; alu_select = ALU_OR;   end
      OPC_SHR:  begin op_class = CLS_RR; alu_select = ALU_SHR;  end
      OPC_SHRA: begin op_class = CLS_RR; alu_select = ALU_SHRA; end
      OPC_SHL:  begin op_class = CLS_RR; alu_select = ALU_SHL;  end
      OPC_ROR:  begin op_class = CLS_RR; alu_select = ALU_ROR;  end
      OPC_ROL:  begin op_class = CLS_RR; alu_select = ALU_ROL;  end
      OPC_ADDI: begin op_class = CLS_RI; alu_select = ALU_ADD;  end
      OPC_ANDI: begin op_class = CLS_RI; alu_select = ALU_AND;  end
      OPC_ORI:  begin op_class = CLS_RI; alu_select = ALU_OR;   end
      OPC_NEG:  begin op_class = CLS_UN; alu_select = ALU_NEG;  end
      OPC_NOT:  begin op_class = CLS_UN; alu_select = ALU_NOT;  end
      OPC_MUL:  begin op_class = CLS_MD; alu_select = ALU_MUL;  end
      OPC_DIV:  begin op_class = CLS_MD; alu_select = ALU_DIV;  end
      default:  begin op_class = CLS_ILL; alu_select = ALU_NOP; end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU T-state sequencer: captures one decoded instruction per start pulse and
// drives register-file, latch, bus-driver and writeback strobes per state.
//
//  state | meaning
//  IDLE  | waiting for start; all outputs 0
//  T3    | first operand onto bus, load Y
//  T4    | second operand / immediate onto bus, ALU op valid, load Z
//  T5    | Z low onto bus, write Rd (or LO for mul/div)
//  T6    | Z high onto bus, write HI (mul/div only)
//  DONE  | completion pulse (plus illegal for unknown opcodes)
module alu_op_sequencer
  import cpu_ops_pkg::*;
(
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [OP_W-1:0]  opcode,
  input  logic [RA_W-1:0]  ra,
  input  logic [RA_W-1:0]  rb,
  input  logic [RA_W-1:0]  rc,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [SEL_W-1:0] alu_select,
  output logic [RA_W-1:0]  rf_rsel,
  output logic             rf_out,
  output logic             c_out,
  output logic             y_in,
  output logic             z_in,
  output logic             zlow_out,
  output logic             zhigh_out,
  output logic             lo_in,
  output logic             hi_in,
  output logic [RA_W-1:0]  rf_wsel,
  output logic             rf_we
);

  logic [2:0]       state, state_nxt;
  op_class_e        cls_q;
  logic [SEL_W-1:0] sel_q;
  logic [RA_W-1:0]  ra_q, rb_q, rc_q;

  op_class_e        dec_class;
  logic [SEL_W-1:0] dec_select;

  alu_op_decode u_decode (
    .opcode     (opcode),
    .op_class   (dec_class),
    .alu_select (dec_select)
  );

  // Next-state logic; class of the incoming opcode picks the entry state
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        if (!start)                   state_nxt = ST_IDLE;
        else if (dec_class == CLS_ILL) state_nxt = ST_DONE;
        else if (dec_class == CLS_UN)  state_nxt = ST_T4;
        else                           state_nxt = ST_T3;
      end
      ST_T3:   state_nxt = ST_T4;
      ST_T4:   state_nxt = ST_T5;
      ST_T5:   state_nxt = (cls_q == CLS_MD) ? ST_T6 : ST_DONE;
      ST_T6:   state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and field capture; hold freezes both, reset overrides hold
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state <= ST_IDLE;
      cls_q <= CLS_RR;
      sel_q <= ALU_NOP;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else if (!hold) begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        cls_q <= dec_class;
        sel_q <= dec_select;
        ra_q  <= ra;
        rb_q  <= rb;
        rc_q  <= rc;
      end
    end
  end

  // Moore output decode; hold only gates write strobes and the done pulse
  always_comb begin
    busy       = (state != ST_IDLE);
    done       = 1'b0;
    illegal    = 1'b0;
    alu_select = ALU_NOP;
    rf_rsel    = '0;
    rf_out     = 1'b0;
    c_out      = 1'b0;
    y_in       = 1'b0;
    z_in       = 1'b0;
    zlow_out   = 1'b0;
    zhigh_out  = 1'b0;
    lo_in      = 1'b0;
    hi_in      = 1'b0;
    rf_wsel    = '0;
    rf_we      = 1'b0;
    case (state)
      ST_T3: begin
        rf_out     = 1'b1;
        rf_rsel    = (cls_q == CLS_MD) ? ra_q : rb_q;
        y_in       = !hold;
        alu_select = sel_q;
      end
      ST_T4: begin
        alu_select = sel_q;
        z_in       = !hold;
        case (cls_q)
          CLS_RR:  begin rf_out = 1'b1; rf_rsel = rc_q; end
          CLS_RI:  c_out = 1'b1;
          CLS_UN:  begin rf_out = 1'b1; rf_rsel = rb_q; end
          CLS_MD:  begin rf_out = 1'b1; rf_rsel = rb_q; end
          default: ;
        endcase
      end
      ST_T5: begin
        zlow_out = 1'b1;
        if (cls_q == CLS_MD) begin
          lo_in = !hold;
        end else begin
          rf_wsel = ra_q;
          rf_we   = !hold;
        end
      end
      ST_T6: begin
        zhigh_out = 1'b1;
        hi_in     = !hold;
      end
      ST_DONE: begin
        done    = !hold;
        illegal = !hold && (cls_q == CLS_ILL);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench: each test pushes its per-cycle expected output vectors,
// a negedge monitor pops one per busy cycle and checks idle cycles are quiet.
module tb_alu_op_sequencer;
  import cpu_ops_pkg::*;

  logic             clk = 1'b0;
  logic             clr_n = 1'b0;
  logic             start = 1'b0;
  logic             hold = 1'b0;
  logic [OP_W-1:0]  opcode = '0;
  logic [RA_W-1:0]  ra = '0, rb = '0, rc = '0;
  logic             busy, done, illegal;
  logic [SEL_W-1:0] alu_select;
  logic [RA_W-1:0]  rf_rsel, rf_wsel;
  logic             rf_out, c_out, y_in, z_in, zlow_out, zhigh_out;
  logic             lo_in, hi_in, rf_we;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_q[$];
  logic [23:0] act;
  logic [23:0] mon_exp;
  logic        mon_en = 1'b0;
  string       tag = "reset";

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk(clk), .clr_n(clr_n), .start(start), .opcode(opcode),
    .ra(ra), .rb(rb), .rc(rc), .hold(hold),
    .busy(busy), .done(done), .illegal(illegal), .alu_select(alu_select),
    .rf_rsel(rf_rsel), .rf_out(rf_out), .c_out(c_out), .y_in(y_in),
    .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .rf_wsel(rf_wsel), .rf_we(rf_we)
  );

  assign act = {done, illegal, alu_select, rf_rsel, rf_out, c_out, y_in, z_in,
                zlow_out, zhigh_out, lo_in, hi_in, rf_wsel, rf_we};

  // Expected vector: done illegal sel rsel rf_out c_out y_in z_in zlow zhigh lo hi wsel we
  function automatic logic [23:0] ev(input logic dn, input logic il,
                                     input logic [4:0] s, input logic [3:0] rs,
                                     input logic ro, input logic co, input logic yi,
                                     input logic zi, input logic zl, input logic zh,
                                     input logic lo, input logic hi,
                                     input logic [3:0] ws, input logic we);
    return {dn, il, s, rs, ro, co, yi, zi, zl, zh, lo, hi, ws, we};
  endfunction

  // Monitor: busy cycles consume one expected vector, idle cycles must be all-zero
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s unexpected_busy t=%0t actual=%h required=idle", tag, $time, act);
        end else begin
          mon_exp = exp_q.pop_front();
          if (act !== mon_exp) begin
            errors++;
            $display("FAIL %s cycle t=%0t actual=%h required=%h", tag, $time, act, mon_exp);
          end
        end
      end else if (busy !== 1'b0 || act !== 24'h0) begin
        errors++;
        $display("FAIL %s idle t=%0t busy=%b actual=%h required=000000", tag, $time, busy, act);
      end
      checks++;
      if ($countones({rf_out, c_out, zlow_out, zhigh_out}) > 1) begin
        errors++;
        $display("FAIL %s bus_exclusive t=%0t actual=%b required=onehot0", tag, $time,
                 {rf_out, c_out, zlow_out, zhigh_out});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [RA_W-1:0] a,
                       input logic [RA_W-1:0] b, input logic [RA_W-1:0] c);
    opcode = op; ra = a; rb = b; rc = c;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pending=%0d required=0", tag, exp_q.size());
      exp_q.delete();
    end
    tick(1);
  endtask

  initial begin
    clr_n = 1'b0;
    tick(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy actual=%b required=0", busy);
    end
    checks++;
    if (act !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs actual=%h required=000000", act);
    end
    clr_n = 1'b1;
    mon_en = 1'b1;
    tick(1);

    tag = "add";
    exp_q.push_back(ev(0,0,ALU_ADD,2,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,3,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,1,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_ADD, 4'd1, 4'd2, 4'd3);
    drain();

    tag = "addi";
    exp_q.push_back(ev(0,0,ALU_ADD,5,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,0,0,1,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,4,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_ADDI, 4'd4, 4'd5, 4'd7);
    drain();

    tag = "mul";
    exp_q.push_back(ev(0,0,ALU_MUL,6,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_MUL,7,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,1,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,0,1,0,1,0,0));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_MUL, 4'd6, 4'd7, 4'd2);
    drain();

    tag = "div";
    exp_q.push_back(ev(0,0,ALU_DIV,10,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_DIV,11,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,1,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,0,1,0,1,0,0));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_DIV, 4'd10, 4'd11, 4'd12);
    drain();

    tag = "not";
    exp_q.push_back(ev(0,0,ALU_NOT,9,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,8,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_NOT, 4'd8, 4'd9, 4'd1);
    drain();

    tag = "shra";
    exp_q.push_back(ev(0,0,ALU_SHRA,3,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_SHRA,4,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,2,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_SHRA, 4'd2, 4'd3, 4'd4);
    drain();

    tag = "illegal";
    exp_q.push_back(ev(1,1,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(5'd31, 4'd1, 4'd2, 4'd3);
    drain();

    // start while busy (illegal opcode) and during DONE must both be ignored
    tag = "sub_start_busy";
    exp_q.push_back(ev(0,0,ALU_SUB,4,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_SUB,5,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,3,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_SUB, 4'd3, 4'd4, 4'd5);
    tick(1);
    opcode = 5'd31; ra = 4'd9; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    opcode = OPC_NOT; start = 1'b1;
    tick(1);
    start = 1'b0;
    drain();

    tag = "start_with_hold";
    hold = 1'b1;
    opcode = OPC_ADD; start = 1'b1;
    tick(1);
    start = 1'b0; hold = 1'b0;
    tick(3);

    tag = "add_hold_t4";
    exp_q.push_back(ev(0,0,ALU_ADD,2,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,3,1,0,0,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,3,1,0,0,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,3,1,0,0,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,3,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,1,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_ADD, 4'd1, 4'd2, 4'd3);
    tick(1);
    hold = 1'b1;
    tick(3);
    hold = 1'b0;
    drain();

    tag = "neg_hold_done";
    exp_q.push_back(ev(0,0,ALU_NEG,13,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,12,1));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_NEG, 4'd12, 4'd13, 4'd0);
    tick(2);
    hold = 1'b1;
    tick(1);
    hold = 1'b0;
    drain();

    // reset lands in a held T5: no writeback visible, IDLE on the next cycle
    tag = "reset_in_t5";
    exp_q.push_back(ev(0,0,ALU_ADD,6,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_ADD,7,1,0,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,5,0));
    issue(OPC_ADD, 4'd5, 4'd6, 4'd7);
    tick(2);
    hold = 1'b1; clr_n = 1'b0;
    tick(1);
    hold = 1'b0; clr_n = 1'b1;
    drain();

    tag = "ori_r0";
    exp_q.push_back(ev(0,0,ALU_OR,1,1,0,1,0,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_OR,0,0,1,0,1,0,0,0,0,0,0));
    exp_q.push_back(ev(0,0,ALU_NOP,0,0,0,0,0,1,0,0,0,0,1));
    exp_q.push_back(ev(1,0,ALU_NOP,0,0,0,0,0,0,0,0,0,0,0));
    issue(OPC_ORI, 4'd0, 4'd1, 4'hF);
    drain();

    tick(2);
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
